addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined adder/subtractor; successor to the fixed 32-bit combinational add32 tree.
//  Splits a WIDTH-bit add/sub into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
//  Full throughput (1 op/cycle), valid/ready handshake with backpressure, ADD/ADC/SUB/SBB modes and NZCV flags.
//  Sits between the ALU operand latch and writeback.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits added per stage; STAGES = WIDTH/CHUNK (1..WIDTH)
// PORTS
//  m_clock    in   1      single clock, rising edge
//  p_reset    in   1      reset, asynchronous, active-low
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      block accepts bundle this cycle
//  op         in   2      00 ADD, 01 ADC, 10 SUB, 11 SBB
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; used by ADC/SBB only
//  out_valid  out  1      result bundle valid
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry out of MSB (SUB/SBB: 1 = no borrow)
//  ov         out  1      signed overflow
//  zero       out  1      out == 0
//  neg        out  1      out[WIDTH-1]
// BEHAVIOUR
//  Reset (p_reset=0, async): all valid bits clear; out_valid=0; out/cout/ov/zero/neg=0; in_ready=1 after release.
//  Effective operands: ADD: b'=b, c0=0; ADC: b'=b, c0=cin; SUB: b'=~b, c0=1; SBB: b'=~b, c0=~cin.
//  Arithmetic: {cout,out} = a + b' + c0, computed in WIDTH+1 bits.
//  Flags:
//   ov   = (a[MSB]==b'[MSB]) & (out[MSB]!=a[MSB])
//   zero = AND of per-slice zero bits, accumulated along the pipe
//   neg  = out[MSB]
//  Stage k (0..STAGES-1) adds slice k plus the registered carry from stage k-1.
//   It forwards the completed low slices, the unprocessed high slices of a and b', and the zero accumulator.
//  Handshake:
//   Global advance adv = ~out_valid | out_ready; in_ready = adv.
//   Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   When adv=0 every stage holds, including bubbles.
//   When adv=1 all stages shift, and an empty input slot enters as a bubble (valid=0).
//  Latency: STAGES cycles from accept to out_valid with no stall; order is preserved; no drop, no duplicate.
//  Output registers stay stable while out_valid & ~out_ready.
//  Reset mid-operation: all in-flight ops are discarded and never appear at the output.
//  STAGES=1: behaves as a registered single-cycle adder with the same handshake.
//  Inputs are sampled only on an accepted transfer; values are don't-care otherwise.
// STRUCTURE
//  Package addsub_pkg: op encodings (OP_ADD/OP_ADC/OP_SUB/OP_SBB), op_t typedef, flags struct {n,z,c,v}.
//  Sub-module addsub_slice: CHUNK-bit combinational adder, (a,b,ci) -> (s,co,z).
//   Instantiated STAGES times via generate.
//  Top holds the per-stage pipeline registers and the valid/advance logic.
// TESTING (WIDTH=32, CHUNK=8, latency 4 unless stated)
//  ADD 0xFFFFFFFF+0x00000001
//   -> 4 cycles later out=0, cout=1, ov=0, zero=1, neg=0.
//  ADD 0x7FFFFFFF+0x00000001
//   -> out=0x80000000, ov=1, neg=1, cout=0.
//  SUB 5-7
//   -> out=0xFFFFFFFE, cout=0, ov=0, neg=1.
//  SBB 0x10-0x10 with cin=1
//   -> out=0xFFFFFFFF, cout=0.
//  ADC 0xFF+0x00 with cin=1
//   -> out=0x100 (carry crosses a slice), cout=0.
//  Stream 8 back-to-back ops with out_ready pseudo-random
//   -> results match the reference model in order; out held stable during stalls; in_ready==adv every cycle.
//  Drive p_reset=0 with 3 ops in flight
//   -> out_valid=0 asynchronously; after release no stale result emerges.
//  Rerun with CHUNK=32 (1 stage) and CHUNK=4 (8 stages)
//   -> same results, latency 1 and 8 respectively.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared encodings and helpers for the pipelined adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ADC = 2'b01,
      OP_SUB = 2'b10,
      OP_SBB = 2'b11
   } op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Carry into bit 0: subtraction is a + ~b + 1, and SBB uses the inverted borrow.
   function automatic logic carry_in0(input op_t op, input logic cin);
      case (op)
         OP_ADD:  return 1'b0;
         OP_ADC:  return cin;
         OP_SUB:  return 1'b1;
         default: return ~cin;
      endcase
   endfunction

   function automatic logic signed_ov(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit combinational adder slice with carry-out and slice-zero detect.
module addsub_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             ci_i,
   output logic [CHUNK-1:0] s_o,
   output logic             co_o,
   output logic             z_o
);

   logic [CHUNK:0] sum;

   assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
   assign s_o  = sum[CHUNK-1:0];
   assign co_o = sum[CHUNK];
   assign z_o  = ~|sum[CHUNK-1:0];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, with a
// single global advance so the whole pipe stalls together under backpressure.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ov,
   output logic             zero,
   output logic             neg
);

   localparam int STAGES = WIDTH / CHUNK;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic             ov_q;
   flags_t           flags;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign b_eff    = op[1] ? ~b : b;
   assign c0       = carry_in0(op_t'(op), cin);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - (k + 1) * CHUNK;

      logic [WIDTH-1:0] a_in, a_d, a_q;
      logic [CHUNK-1:0] b_sl, s_w;
      logic             c_in, z_in, v_in, co_w, z_w;
      logic             c_q, z_q, vld_q;

      if (k == 0) begin : g_head
         assign a_in = a;
         assign b_sl = b_eff[CHUNK-1:0];
         assign c_in = c0;
         assign z_in = 1'b1;
         assign v_in = in_valid;
      end else begin : g_body
         assign a_in = g_stage[k-1].a_q;
         assign b_sl = g_stage[k-1].g_rem.b_q[CHUNK-1:0];
         assign c_in = g_stage[k-1].c_q;
         assign z_in = g_stage[k-1].z_q;
         assign v_in = g_stage[k-1].vld_q;
      end

      // The a word carries finished low slices and still-untouched high slices of a.
      addsub_slice #(.CHUNK(CHUNK)) u_slice (
         .a_i  (a_in[k*CHUNK +: CHUNK]),
         .b_i  (b_sl),
         .ci_i (c_in),
         .s_o  (s_w),
         .co_o (co_w),
         .z_o  (z_w)
      );

      always_comb begin
         a_d                   = a_in;
         a_d[k*CHUNK +: CHUNK] = s_w;
      end

      always_ff @(posedge m_clock or negedge p_reset) begin
         if (!p_reset) begin
            vld_q <= 1'b0;
            a_q   <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
         end else if (adv) begin
            vld_q <= v_in;
            a_q   <= a_d;
            c_q   <= co_w;
            z_q   <= z_in & z_w;
         end
      end

      // Only the b' slices not yet consumed travel on; the register narrows each stage.
      if (REM > 0) begin : g_rem
         logic [REM-1:0] b_d, b_q;

         if (k == 0) begin : g_src
            assign b_d = b_eff[WIDTH-1:CHUNK];
         end else begin : g_src
            assign b_d = g_stage[k-1].g_rem.b_q[REM+CHUNK-1:CHUNK];
         end

         always_ff @(posedge m_clock or negedge p_reset) begin
            if (!p_reset)  b_q <= '0;
            else if (adv)  b_q <= b_d;
         end
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         ov_q <= 1'b0;
      end else if (adv) begin
         ov_q <= signed_ov(g_stage[STAGES-1].a_in[WIDTH-1],
                           g_stage[STAGES-1].b_sl[CHUNK-1],
                           g_stage[STAGES-1].s_w[CHUNK-1]);
      end
   end

   assign flags.n = g_stage[STAGES-1].a_q[WIDTH-1];
   assign flags.z = g_stage[STAGES-1].z_q;
   assign flags.c = g_stage[STAGES-1].c_q;
   assign flags.v = ov_q;

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign out       = g_stage[STAGES-1].a_q;
   assign cout      = flags.c;
   assign ov        = flags.v;
   assign zero      = flags.z;
   assign neg       = flags.n;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed singles with literal expectations, a stalled
// stream checked against an arithmetic model, and a mid-flight reset.
module tb_addsub_pipe;

   parameter int CHUNK = 8;
   localparam int WIDTH  = 32;
   localparam int STAGES = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, cin, out_valid, out_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a, b, res;
   logic             cout, ov, zero, neg;

   int n_chk  = 0;
   int n_fail = 0;

   addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .m_clock   (clk),
      .p_reset   (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (res),
      .cout      (cout),
      .ov        (ov),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic             c, v, z, n;
   } exp_t;

   exp_t exp_q[$];

   // Reference: plain integer arithmetic; carry/borrow and signed range decide the flags.
   function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y, input logic ci);
      exp_t   e;
      longint ux, uy, sx, sy, k, full, sfull, maxs, mins;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      k    = (o == 2'b00 || o == 2'b10) ? 0 : longint'(ci);
      maxs = (longint'(1) <<< (WIDTH - 1)) - 1;
      mins = -(longint'(1) <<< (WIDTH - 1));
      if (!o[1]) begin
         full  = ux + uy + k;
         sfull = sx + sy + k;
         e.c   = (full >= (longint'(1) <<< WIDTH));
      end else begin
         full  = ux - uy - k;
         sfull = sx - sy - k;
         e.c   = (ux >= uy + k);
      end
      e.r = full[WIDTH-1:0];
      e.v = (sfull > maxs) || (sfull < mins);
      e.z = (e.r == '0);
      e.n = e.r[WIDTH-1];
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Per-cycle compare: handshake identity, hold during stall, in-order results.
   logic             prev_stall = 1'b0;
   logic [WIDTH+4:0] prev_snap;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_eq_adv", in_ready, !out_valid || out_ready);
         if (prev_stall)
            chk("hold_during_stall", {out_valid, res, cout, ov, zero, neg}, prev_snap);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1'b1, 1'b0);
            end else begin
               e = exp_q[0];
               chk("stream_out",  res,  e.r);
               chk("stream_cout", cout, e.c);
               chk("stream_ov",   ov,   e.v);
               chk("stream_zero", zero, e.z);
               chk("stream_neg",  neg,  e.n);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_snap  = {out_valid, res, cout, ov, zero, neg};
         if (in_valid && in_ready) exp_q.push_back(model(op, a, b, cin));
      end
   end

   logic rnd_rdy = 1'b0;

   task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic c);
      logic acc;
      int   w;
      w  = 0;
      op = o; a = x; b = y; cin = c;
      in_valid = 1'b1;
      do begin
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         w++;
      end while (!acc && w < 50);
      if (!acc) chk("send_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic single(input string name, input logic [1:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic c, input logic [WIDTH-1:0] er,
                         input logic ec, input logic ev, input logic ez, input logic en);
      int cnt;
      out_ready = 1'b1;
      send(o, x, y, c);
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({name, "_latency"}, cnt, STAGES);
      chk({name, "_out"},  res,  er);
      chk({name, "_cout"}, cout, ec);
      chk({name, "_ov"},   ov,   ev);
      chk({name, "_zero"}, zero, ez);
      chk({name, "_neg"},  neg,  en);
      @(posedge clk);
      #1;
   endtask

   logic [1:0]       s_op [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
   logic [WIDTH-1:0] s_a  [8] = '{32'h1234_5678, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [WIDTH-1:0] s_b  [8] = '{32'h1111_1111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001,
                                  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
   logic             s_c  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int w;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'b00; a = '0; b = '0; cin = 1'b0;
      #3;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out",  res,  '0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ov",   ov,   1'b0);
      chk("rst_zero", zero, 1'b0);
      chk("rst_neg",  neg,  1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1'b1);

      single("add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
      single("add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
      single("sub_neg",   2'b10, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 1);
      single("sbb_borrow",2'b11, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 0, 0, 0, 1);
      single("adc_cross", 2'b01, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 0, 0, 0, 0);

      rnd_rdy = 1'b1;
      for (int i = 0; i < 8; i++) send(s_op[i], s_a[i], s_b[i], s_c[i]);
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("stream_drained", exp_q.size(), 0);

      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(2'b00, 32'h100 + i, 32'h1, 1'b0);
      out_ready = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("inflight_valid", out_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_out",   res,       '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (STAGES + 3) @(posedge clk);
      #1;
      chk("no_stale_after_rst", out_valid, 1'b0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
